// File: rtl/heading_sprite_if.sv
// Pixel-stream bundle between the timing generator side and the sprite renderer.
interface heading_sprite_if;
   logic               pix_valid_in;
   logic signed [11:0] x_value;
   logic signed [11:0] y_value;
   logic               pix_valid_out;
   logic [23:0]        pixel;
   logic               hit;

   // Source of pixel coordinates, sink of rendered colour
   modport master (
      output pix_valid_in, x_value, y_value,
      input  pix_valid_out, pixel, hit
   );

   // Renderer side
   modport slave (
      input  pix_valid_in, x_value, y_value,
      output pix_valid_out, pixel, hit
   );
endinterface

// File: rtl/heading_sprite.sv
// Pipelined sprite renderer: square/diamond body plus a blinking heading ray,
// 4-stage fixed latency, geometry double-buffered on frame_start.
module heading_sprite #(
   parameter int unsigned WIDTH           = 64,
   parameter int unsigned HEIGHT          = 64,
   parameter logic [23:0] COLOR           = 24'hFF_FF_FF,
   parameter logic [23:0] BLANK_COLOR     = 24'h00_00_00,
   parameter logic [23:0] INDICATOR_COLOR = 24'h00_FF_00,
   parameter int unsigned TOLERANCE       = 1,
   parameter int unsigned BLINK_BITS      = 5
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               frame_start,
   input  logic signed [11:0] center_x_in,
   input  logic signed [11:0] center_y_in,
   input  logic [4:0]         orientation_in,
   input  logic               mode_in,
   input  logic               blink_en_in,
   heading_sprite_if.slave    pix
);

   localparam int unsigned CW   = 12;  // coordinate width
   localparam int unsigned DW   = 13;  // coordinate difference width
   localparam int unsigned TW   = 9;   // trig Q1.7 width
   localparam int unsigned PW   = 22;  // cross / along width
   localparam int unsigned SW   = 14;  // |dx|+|dy| width
   localparam int unsigned NHDG = 24;

   localparam logic signed [DW-1:0] HALF_W  = DW'(WIDTH / 2);
   localparam logic signed [DW-1:0] HALF_H  = DW'(HEIGHT / 2);
   localparam logic [SW-1:0]        DIA_LIM = SW'(WIDTH / 2);
   localparam logic [PW-1:0]        TOL_LIM = PW'(TOLERANCE * 128);

   // Active (frame-latched) geometry
   logic signed [CW-1:0]  cx_q, cy_q;
   logic [4:0]            ori_q;
   logic                  mode_q;
   logic                  blink_q;
   logic [BLINK_BITS-1:0] cnt_q;

   // Stage 1 registers
   logic                 v1_q;
   logic signed [DW-1:0] dx1_q, dy1_q;
   logic [DW-1:0]        adx1_q, ady1_q;
   logic signed [TW-1:0] cos1_q, sin1_q;
   logic                 mode1_q, show1_q;

   // Stage 2 registers
   logic                 v2_q;
   logic                 inside2_q;
   logic signed [PW-1:0] cross2_q, along2_q;
   logic                 show2_q;

   // Stage 3 registers
   logic v3_q, inside3_q, on_ray3_q, show3_q;

   // Stage 4 (output) registers
   logic        pix_valid_out_q;
   logic [23:0] pixel_q;
   logic        hit_q;

   // Combinational intermediates
   logic [4:0]           ori_eff_c;
   logic signed [TW-1:0] cos_c, sin_c;
   logic signed [DW-1:0] dx_c, dy_c;
   logic [DW-1:0]        adx_c, ady_c;
   logic                 show_c;
   logic                 in_sq_c, in_dia_c, inside_c;
   logic signed [PW-1:0] cross_c, along_c;
   logic [PW-1:0]        abs_cross_c;
   logic                 on_ray_c;
   logic [23:0]          pixel_d;
   logic                 hit_d;

   // Shadow-to-active copy and frame counter on each frame_start edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cx_q    <= '0;
         cy_q    <= '0;
         ori_q   <= '0;
         mode_q  <= 1'b0;
         blink_q <= 1'b0;
         cnt_q   <= '0;
      end else if (frame_start) begin
         cx_q    <= center_x_in;
         cy_q    <= center_y_in;
         ori_q   <= orientation_in;
         mode_q  <= mode_in;
         blink_q <= blink_en_in;
         cnt_q   <= cnt_q + BLINK_BITS'(1);
      end
   end

   // Headings outside 0..23 fold to heading 0
   always_comb begin
      ori_eff_c = (ori_q >= 5'(NHDG)) ? 5'd0 : ori_q;
   end

   // Sin/cos ROM, round(128*cos), round(128*sin), 15 degree steps CCW from +x
   always_comb begin
      cos_c = 9'sd128;
      sin_c = 9'sd0;
      case (ori_eff_c)
         5'd0 : begin cos_c =  9'sd128; sin_c =  9'sd0;   end
         5'd1 : begin cos_c =  9'sd124; sin_c =  9'sd33;  end
         5'd2 : begin cos_c =  9'sd111; sin_c =  9'sd64;  end
         5'd3 : begin cos_c =  9'sd91;  sin_c =  9'sd91;  end
         5'd4 : begin cos_c =  9'sd64;  sin_c =  9'sd111; end
         5'd5 : begin cos_c =  9'sd33;  sin_c =  9'sd124; end
         5'd6 : begin cos_c =  9'sd0;   sin_c =  9'sd128; end
         5'd7 : begin cos_c = -9'sd33;  sin_c =  9'sd124; end
         5'd8 : begin cos_c = -9'sd64;  sin_c =  9'sd111; end
         5'd9 : begin cos_c = -9'sd91;  sin_c =  9'sd91;  end
         5'd10: begin cos_c = -9'sd111; sin_c =  9'sd64;  end
         5'd11: begin cos_c = -9'sd124; sin_c =  9'sd33;  end
         5'd12: begin cos_c = -9'sd128; sin_c =  9'sd0;   end
         5'd13: begin cos_c = -9'sd124; sin_c = -9'sd33;  end
         5'd14: begin cos_c = -9'sd111; sin_c = -9'sd64;  end
         5'd15: begin cos_c = -9'sd91;  sin_c = -9'sd91;  end
         5'd16: begin cos_c = -9'sd64;  sin_c = -9'sd111; end
         5'd17: begin cos_c = -9'sd33;  sin_c = -9'sd124; end
         5'd18: begin cos_c =  9'sd0;   sin_c = -9'sd128; end
         5'd19: begin cos_c =  9'sd33;  sin_c = -9'sd124; end
         5'd20: begin cos_c =  9'sd64;  sin_c = -9'sd111; end
         5'd21: begin cos_c =  9'sd91;  sin_c = -9'sd91;  end
         5'd22: begin cos_c =  9'sd111; sin_c = -9'sd64;  end
         5'd23: begin cos_c =  9'sd124; sin_c = -9'sd33;  end
         default: begin cos_c = 9'sd128; sin_c = 9'sd0; end
      endcase
   end

   // Stage 1 combinational: centre-relative offsets (y flipped so up is positive)
   always_comb begin
      dx_c   = {pix.x_value[CW-1], pix.x_value} - {cx_q[CW-1], cx_q};
      dy_c   = {cy_q[CW-1], cy_q} - {pix.y_value[CW-1], pix.y_value};
      adx_c  = dx_c[DW-1] ? DW'(-dx_c) : DW'(dx_c);
      ady_c  = dy_c[DW-1] ? DW'(-dy_c) : DW'(dy_c);
      show_c = !blink_q || !cnt_q[BLINK_BITS-1];
   end

   // Stage 1 register: offsets, trig values and frame-latched attributes
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         v1_q    <= 1'b0;
         dx1_q   <= '0;
         dy1_q   <= '0;
         adx1_q  <= '0;
         ady1_q  <= '0;
         cos1_q  <= '0;
         sin1_q  <= '0;
         mode1_q <= 1'b0;
         show1_q <= 1'b0;
      end else begin
         v1_q    <= pix.pix_valid_in;
         dx1_q   <= dx_c;
         dy1_q   <= dy_c;
         adx1_q  <= adx_c;
         ady1_q  <= ady_c;
         cos1_q  <= cos_c;
         sin1_q  <= sin_c;
         mode1_q <= mode_q;
         show1_q <= show_c;
      end
   end

   // Stage 2 combinational: body inside test and exact cross/along products
   always_comb begin
      in_sq_c  = (dx1_q >= -HALF_W) && (dx1_q < HALF_W) &&
                 (dy1_q > -HALF_H) && (dy1_q <= HALF_H);
      in_dia_c = (SW'(adx1_q) + SW'(ady1_q)) <= DIA_LIM;
      inside_c = mode1_q ? in_dia_c : in_sq_c;
      cross_c  = (PW'(dx1_q) * PW'(sin1_q)) - (PW'(dy1_q) * PW'(cos1_q));
      along_c  = (PW'(dx1_q) * PW'(cos1_q)) + (PW'(dy1_q) * PW'(sin1_q));
   end

   // Stage 2 register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         v2_q      <= 1'b0;
         inside2_q <= 1'b0;
         cross2_q  <= '0;
         along2_q  <= '0;
         show2_q   <= 1'b0;
      end else begin
         v2_q      <= v1_q;
         inside2_q <= inside_c;
         cross2_q  <= cross_c;
         along2_q  <= along_c;
         show2_q   <= show1_q;
      end
   end

   // Stage 3 combinational: forward half-ray within the tolerance band
   always_comb begin
      abs_cross_c = cross2_q[PW-1] ? PW'(-cross2_q) : PW'(cross2_q);
      on_ray_c    = inside2_q && !along2_q[PW-1] && (abs_cross_c <= TOL_LIM);
   end

   // Stage 3 register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         v3_q      <= 1'b0;
         inside3_q <= 1'b0;
         on_ray3_q <= 1'b0;
         show3_q   <= 1'b0;
      end else begin
         v3_q      <= v2_q;
         inside3_q <= inside2_q;
         on_ray3_q <= on_ray_c;
         show3_q   <= show2_q;
      end
   end

   // Stage 4 combinational: colour select
   always_comb begin
      pixel_d = BLANK_COLOR;
      hit_d   = 1'b0;
      if (v3_q) begin
         hit_d = inside3_q;
         if (on_ray3_q && show3_q) begin
            pixel_d = INDICATOR_COLOR;
         end else if (inside3_q) begin
            pixel_d = COLOR;
         end
      end
   end

   // Stage 4 register: outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pix_valid_out_q <= 1'b0;
         pixel_q         <= BLANK_COLOR;
         hit_q           <= 1'b0;
      end else begin
         pix_valid_out_q <= v3_q;
         pixel_q         <= pixel_d;
         hit_q           <= hit_d;
      end
   end

   assign pix.pix_valid_out = pix_valid_out_q;
   assign pix.pixel         = pixel_q;
   assign pix.hit           = hit_q;

endmodule

// File: tb/tb_heading_sprite.sv
// Scoreboard bench for heading_sprite: driver pushes expected colour/hit,
// monitor pops and compares on every pix_valid_out.
module tb_heading_sprite;

   localparam logic [23:0] IND = 24'h00_FF_00;
   localparam logic [23:0] COL = 24'hFF_FF_FF;
   localparam logic [23:0] BLK = 24'h00_00_00;

   typedef struct {
      logic [23:0] px;
      logic        h;
      string       name;
   } exp_t;

   logic               clock = 1'b0;
   logic               reset_n;
   logic               frame_start;
   logic signed [11:0] cxi, cyi;
   logic [4:0]         ori;
   logic               mode, blink;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   heading_sprite_if bus ();

   heading_sprite #(.BLINK_BITS(2)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .frame_start    (frame_start),
      .center_x_in    (cxi),
      .center_y_in    (cyi),
      .orientation_in (ori),
      .mode_in        (mode),
      .blink_en_in    (blink),
      .pix            (bus)
   );

   always #5 clock = ~clock;

   // Monitor: every output beat must match the oldest outstanding expectation
   always @(negedge clock) begin
      if (reset_n === 1'b1 && bus.pix_valid_out === 1'b1) begin
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: pixel=%h hit=%b with nothing expected",
                     bus.pixel, bus.hit);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (bus.pixel !== e.px || bus.hit !== e.h) begin
               n_fail++;
               $display("FAIL %s: got pixel=%h hit=%b, expected pixel=%h hit=%b",
                        e.name, bus.pixel, bus.hit, e.px, e.h);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic issue(input int x, input int y, input logic [23:0] px, input logic h,
                        input string nm, input logic fs = 1'b0);
      @(negedge clock);
      frame_start      = fs;
      bus.pix_valid_in = 1'b1;
      bus.x_value      = 12'(x);
      bus.y_value      = 12'(y);
      q.push_back('{px, h, nm});
   endtask

   task automatic frame();
      @(negedge clock);
      bus.pix_valid_in = 1'b0;
      frame_start      = 1'b1;
      @(negedge clock);
      frame_start      = 1'b0;
   endtask

   task automatic drain();
      int t;
      @(negedge clock);
      bus.pix_valid_in = 1'b0;
      frame_start      = 1'b0;
      t = 0;
      while (q.size() != 0 && t < 40) begin
         @(negedge clock);
         t++;
      end
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d outputs still outstanding, expected 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n          = 1'b0;
      frame_start      = 1'b0;
      cxi = '0; cyi = '0; ori = '0; mode = 1'b0; blink = 1'b0;
      bus.pix_valid_in = 1'b1;
      bus.x_value      = '0;
      bus.y_value      = '0;

      // T1: reset holds outputs idle even with valid input
      repeat (3) @(negedge clock);
      check("t1_rst_pixel", 32'(bus.pixel), 32'(BLK));
      check("t1_rst_hit", 32'(bus.hit), 32'd0);
      check("t1_rst_valid", 32'(bus.pix_valid_out), 32'd0);
      // Reset geometry: centre (0,0), heading 0 -> pixel (0,0) is the ray origin
      @(negedge clock);
      reset_n = 1'b1;
      q.push_back('{IND, 1'b1, "t1_origin"});
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         check($sformatf("t1_latency_c%0d", k), 32'(bus.pix_valid_out), (k == 4) ? 32'd1 : 32'd0);
         if (k < 4) q.push_back('{IND, 1'b1, "t1_origin"});
         else       bus.pix_valid_in = 1'b0;
      end
      drain();

      // T2: heading 0, centre (320,240), square 64x64
      cxi = 12'sd320; cyi = 12'sd240; ori = 5'd0; mode = 1'b0; blink = 1'b0;
      frame();
      issue(330, 240, IND, 1'b1, "t2_fwd_ray");
      issue(310, 240, COL, 1'b1, "t2_back_ray");
      issue(330, 243, COL, 1'b1, "t2_off_ray");
      issue(352, 240, BLK, 1'b0, "t2_right_edge_out");
      issue(320, 240, IND, 1'b1, "t2_centre");
      issue(330, 239, IND, 1'b1, "t2_tol_edge_in");
      issue(330, 238, COL, 1'b1, "t2_tol_edge_out");
      issue(288, 240, COL, 1'b1, "t2_left_edge_in");
      issue(310, 208, COL, 1'b1, "t2_top_edge_in");
      issue(310, 272, BLK, 1'b0, "t2_bottom_edge_out");
      drain();

      // T3: other headings
      ori = 5'd6; frame();
      issue(320, 230, IND, 1'b1, "t3_h6_up");
      issue(320, 250, COL, 1'b1, "t3_h6_down");
      ori = 5'd3; frame();
      issue(330, 230, IND, 1'b1, "t3_h3_diag");
      issue(330, 250, COL, 1'b1, "t3_h3_off");
      ori = 5'd12; frame();
      issue(310, 240, IND, 1'b1, "t3_h12_left");
      issue(330, 240, COL, 1'b1, "t3_h12_right");
      ori = 5'd18; frame();
      issue(320, 250, IND, 1'b1, "t3_h18_down");
      issue(320, 230, COL, 1'b1, "t3_h18_up");
      ori = 5'd1; frame();
      issue(340, 235, IND, 1'b1, "t3_h1_near");
      issue(340, 230, COL, 1'b1, "t3_h1_far");
      ori = 5'd9; frame();
      issue(310, 230, IND, 1'b1, "t3_h9_diag");
      drain();

      // T4: shadow change mid-frame takes effect only at frame_start
      ori = 5'd0; frame();
      cxi = 12'sd100;
      issue(330, 240, IND, 1'b1, "t4_mid_frame_old");
      issue(330, 240, IND, 1'b1, "t4_same_edge_old", 1'b1);
      issue(330, 240, BLK, 1'b0, "t4_after_new");
      issue(110, 240, IND, 1'b1, "t4_after_new_ray");
      drain();

      // Centre beyond the screen edge, negative coordinates
      cxi = -12'sd10; cyi = 12'sd5; frame();
      issue(0, 5, IND, 1'b1, "edge_ray");
      issue(-40, 5, COL, 1'b1, "edge_back");
      issue(-43, 5, BLK, 1'b0, "edge_out");
      issue(-5, -20, COL, 1'b1, "edge_above");
      drain();

      // T5: diamond body
      cxi = 12'sd320; cyi = 12'sd240; mode = 1'b1; ori = 5'd0; frame();
      issue(340, 250, COL, 1'b1, "t5_dia_in");
      issue(345, 260, BLK, 1'b0, "t5_dia_out");
      issue(352, 240, IND, 1'b1, "t5_dia_tip");
      issue(353, 240, BLK, 1'b0, "t5_dia_past_tip");
      ori = 5'd27; frame();
      issue(330, 240, IND, 1'b1, "t5_ori27_fwd");
      issue(310, 240, COL, 1'b1, "t5_ori27_back");
      drain();

      // Async reset mid-stream: in-flight pixels are discarded
      mode = 1'b0;
      issue(330, 240, COL, 1'b1, "discard");
      issue(330, 240, COL, 1'b1, "discard");
      issue(330, 240, COL, 1'b1, "discard");
      @(negedge clock);
      reset_n = 1'b0;
      bus.pix_valid_in = 1'b0;
      q.delete();
      #1;
      check("rst_mid_valid", 32'(bus.pix_valid_out), 32'd0);
      repeat (3) @(negedge clock);
      check("rst_mid_pixel", 32'(bus.pixel), 32'(BLK));
      reset_n = 1'b1;
      repeat (8) @(negedge clock);

      // T6: blink with a 2-bit frame counter (counter 0 after reset)
      cxi = 12'sd320; cyi = 12'sd240; ori = 5'd0; blink = 1'b1;
      frame();
      issue(330, 240, IND, 1'b1, "t6_frame1");
      frame();
      issue(330, 240, COL, 1'b1, "t6_frame2");
      frame();
      issue(330, 240, COL, 1'b1, "t6_frame3");
      frame();
      issue(330, 240, IND, 1'b1, "t6_frame4");
      blink = 1'b0;
      frame();
      issue(330, 240, IND, 1'b1, "t6_noblink_f5");
      frame();
      issue(330, 240, IND, 1'b1, "t6_noblink_f6");
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
